// File: rtl/mux.sv
// -----------------------------------------------------------------------------
// mux
//
// Purpose:
//   Select stage of the encoder/multiplexer datapath. It picks one of three
//   data lanes using a 2-bit select code. The block provides three kinds of
//   output:
//     - a combinational result for immediate use,
//     - a registered copy of that result for downstream clocked logic,
//     - error flags that report use of the unused select code 2'b11.
//
// Parameters:
//   LANE_W          width of each data lane (default 1)
//
// Ports:
//   zz              out  LANE_W    combinational selected lane
//   yy              in   3*LANE_W  packed lanes, lane 0 in the low bits
//   ss              in   2         select code: 00/01/10 choose lanes 0/1/2,
//                                  11 is illegal and forces zeros
//   clk             in   1         system clock, rising-edge active
//   rst             in   1         synchronous reset, active-high
//   zz_q            out  LANE_W    zz registered on every rising edge
//   sel_err         out  1         high for one cycle after a cycle with ss==11
//   sel_err_sticky  out  1         set on the first illegal select, cleared
//                                  only by reset
// -----------------------------------------------------------------------------
module mux #(
  parameter int LANE_W = 1
) (
  output logic [LANE_W-1:0]   zz,
  input  logic [3*LANE_W-1:0] yy,
  input  logic [1:0]          ss,
  input  logic                clk,
  input  logic                rst,
  output logic [LANE_W-1:0]   zz_q,
  output logic                sel_err,
  output logic                sel_err_sticky
);

  logic [LANE_W-1:0] lane0;
  logic [LANE_W-1:0] lane1;
  logic [LANE_W-1:0] lane2;
  logic              illegal_sel;

  assign lane0 = yy[LANE_W-1:0];
  assign lane1 = yy[2*LANE_W-1:LANE_W];
  assign lane2 = yy[3*LANE_W-1:2*LANE_W];

  assign illegal_sel = (ss == 2'b11);

  // The illegal code 2'b11 and any unknown select both land in the default
  // branch. This means a bad select never forwards lane data.
  always_comb begin
    zz = '0;
    case (ss)
      2'b00:   zz = lane0;
      2'b01:   zz = lane1;
      2'b10:   zz = lane2;
      default: zz = '0;
    endcase
  end

  // Reset takes priority over a simultaneous illegal select, so the sticky
  // flag stays clear during a reset cycle even when ss is 2'b11.
  always_ff @(posedge clk) begin
    if (rst) begin
      zz_q           <= '0;
      sel_err        <= 1'b0;
      sel_err_sticky <= 1'b0;
    end else begin
      zz_q    <= zz;
      sel_err <= illegal_sel;
      if (illegal_sel) begin
        sel_err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux.sv
// -----------------------------------------------------------------------------
// tb_mux
//
// Purpose:
//   Scoreboard testbench for the mux select stage.
//
// Structure:
//   - The stimulus process drives one input vector per cycle on the falling
//     edge of the clock. For each vector it queues the expected combinational
//     output, together with the registered outputs expected after the
//     following rising edge.
//   - The monitor process pops one entry per cycle. It checks zz shortly
//     after the falling edge, and checks the registered outputs shortly after
//     the next rising edge.
// -----------------------------------------------------------------------------
module tb_mux;

  localparam int LANE_W = 1;

  logic              clk;
  logic              rst;
  logic [2:0]        yy;
  logic [1:0]        ss;
  logic [LANE_W-1:0] zz;
  logic [LANE_W-1:0] zz_q;
  logic              sel_err;
  logic              sel_err_sticky;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic        exp_zz;
    logic        exp_zz_q;
    logic        exp_err;
    logic        exp_sticky;
  } item_t;

  item_t sb_q[$];

  mux #(.LANE_W(LANE_W)) dut (
    .zz             (zz),
    .yy             (yy),
    .ss             (ss),
    .clk            (clk),
    .rst            (rst),
    .zz_q           (zz_q),
    .sel_err        (sel_err),
    .sel_err_sticky (sel_err_sticky)
  );

  // Free-running clock with a 10-time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one observed value with its expected value, counts the check,
  // and prints a FAIL line when they differ.
  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  // Drives one vector at the falling edge and queues the expected results:
  // zz for this cycle, and the registered outputs after the next rising edge.
  task automatic applyStimulus(input string name, input logic r, input logic [2:0] y,
                               input logic [1:0] s, input logic e_zz, input logic e_q,
                               input logic e_err, input logic e_sticky);
    item_t it;
    @(negedge clk);
    rst = r;
    yy  = y;
    ss  = s;
    it.name       = name;
    it.exp_zz     = e_zz;
    it.exp_zz_q   = e_q;
    it.exp_err    = e_err;
    it.exp_sticky = e_sticky;
    sb_q.push_back(it);
  endtask

  // Reference selection rule, used for the exhaustive sweep.
  function automatic logic ref_sel(input logic [2:0] y, input logic [1:0] s);
    case (s)
      2'd0:    return y[0];
      2'd1:    return y[1];
      2'd2:    return y[2];
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: consumes one scoreboard entry per cycle.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        checkOutput({it.name, ".zz"}, zz[0], it.exp_zz);
        @(posedge clk);
        #1;
        checkOutput({it.name, ".zz_q"}, zz_q[0], it.exp_zz_q);
        checkOutput({it.name, ".sel_err"}, sel_err, it.exp_err);
        checkOutput({it.name, ".sticky"}, sel_err_sticky, it.exp_sticky);
      end
    end
  end

  // Stimulus: directed vectors followed by an exhaustive sweep.
  initial begin
    logic       sticky_m;
    logic       e;
    logic [2:0] y3;
    logic [1:0] s2;
    int         wait_cycles;

    rst = 1'b1;
    yy  = 3'b000;
    ss  = 2'b00;

    //            name          rst  yy      ss     zz    zz_q  err   sticky
    applyStimulus("reset",      1'b1, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("s00_y000",   1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("s00_y010",   1'b0, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("s01_y010",   1'b0, 3'b010, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus("s01_y011",   1'b0, 3'b011, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus("s10_y011",   1'b0, 3'b011, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("s10_y100",   1'b0, 3'b100, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus("s10_y000",   1'b0, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("s11_y111",   1'b0, 3'b111, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus("s11_y100",   1'b0, 3'b100, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus("back_s00",   1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("rst_s11",    1'b1, 3'b111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("rst_s01",    1'b1, 3'b010, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("post_rst",   1'b0, 3'b010, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);

    // Exhaustive sweep. The sticky flag is clear at this point and is set
    // by the first ss==11 vector in the sweep.
    sticky_m = 1'b0;
    for (int yi = 0; yi < 8; yi++) begin
      for (int si = 0; si < 4; si++) begin
        y3 = 3'(yi);
        s2 = 2'(si);
        e  = ref_sel(y3, s2);
        if (s2 == 2'b11) sticky_m = 1'b1;
        applyStimulus($sformatf("sweep_y%0d_s%0d", yi, si), 1'b0, y3, s2,
                      e, e, (s2 == 2'b11), sticky_m);
      end
    end

    // Wait for the monitor to drain the queue, with a bounded cycle budget.
    wait_cycles = 0;
    while (sb_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    checks++;
    if (sb_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    @(posedge clk);
    #3;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
